fft_r2_iter: RTL and testbench
==============================

Name: fft_r2_iter

Overview:
- Iterative in-place radix-2 DIT FFT engine of NPTS complex points, signed fixed-point with Q fractional bits.
- Uses one time-shared butterfly per cycle in place of a fully unrolled butterfly stage.
- Samples stream in, the block computes all LOG2N stages, then results stream out in natural order.
- Twiddles are fetched from an external combinational ROM via an address port.
- The block adds overflow handling: selectable per-stage scaling or saturation with a sticky flag.

Parameters:
- N, 16: data and twiddle word width, signed.
- Q, 8: fractional bits of data and twiddles.
- NPTS, 16: FFT length; a power of two, 4..1024.
- LOG2N, 4: log2(NPTS).
- SCALE, 0: 1 = arithmetic shift right by 1 after every stage; 0 = saturate, no scaling.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_r, in_i  in  N  input sample, Q format.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output sample.
- out_r, out_i  out  N  output bin, natural order.
- out_last  out  1  marks bin NPTS-1.
- tw_addr  out  LOG2N-1  twiddle index k.
- tw_r, tw_i  in  N  W^k = cos(2πk/NPTS) - j·sin(2πk/NPTS), Q format; valid in the same cycle as tw_addr.
- busy  out  1  high in COMPUTE.
- ovf  out  1  sticky saturation flag for the current frame.

Behaviour:
- The clock is clk and the reset is rst_n. There is one clock. Reset is asynchronous and active-low.
- States: LOAD, COMPUTE, UNLOAD. Reset state is LOAD.
- Reset values: in_ready=1 once released; out_valid=0, out_last=0, busy=0, ovf=0, out_r=out_i=0, tw_addr=0; all counters 0.
- Storage: register array of NPTS complex words, two reads and two writes per cycle.
- LOAD:
  - in_ready=1.
  - Each in_valid cycle writes the sample at address bitrev(load_cnt), then load_cnt increments.
  - Accepting sample 0 clears ovf.
  - After sample NPTS-1 is accepted, next state is COMPUTE.
- COMPUTE:
  - busy=1, in_ready=0. One butterfly per cycle, counters stage s and butterfly j.
  - Address generation: half=2^s, k=j mod half, a=(j/half)·2·half+k, b=a+half, tw_addr=k·(NPTS/(2·half)).
  - Each cycle reads A=mem[a] and B=mem[b] and writes the results back to the same addresses at that clock edge.
  - Takes LOG2N·NPTS/2 cycles (32 at defaults), then next state is UNLOAD.
- Butterfly arithmetic:
  - P = B·W. Each of the real and imaginary parts is formed at 2N+1 bits and arithmetic-shifted right by Q (truncation toward -inf), giving N+1 bits.
  - Sums are S0 = A+P and S1 = A-P at N+2 bits.
  - SCALE=1: result = S>>>1, then saturated to N bits (saturation is expected only at full-scale corner cases).
  - SCALE=0: result saturated to [-2^(N-1), 2^(N-1)-1].
  - Any saturation sets ovf.
- UNLOAD:
  - out_valid=1 and out_r/out_i = mem[unl_cnt], combinational from the counter. out_last=(unl_cnt==NPTS-1).
  - unl_cnt advances only when out_valid and out_ready are both high. Data is held stable while out_ready=0.
  - After the last bin is accepted, next state is LOAD with counters cleared. Memory is not cleared.
  - Outside UNLOAD, out_r/out_i are forced to 0.
- Frame latency: last input accepted to first out_valid = LOG2N·NPTS/2 + 1 cycles.
- Sustained throughput: one frame per NPTS + LOG2N·NPTS/2 + NPTS cycles when out_ready is held high.
- in_valid outside LOAD is ignored, with no side effects. ovf holds through UNLOAD.
- rst_n asserted mid-frame aborts immediately to the reset values. The partial frame is discarded and no output is produced.

Decomposition:
- Package fft_pkg:
  - state enum;
  - helper to compute LOG2N from NPTS;
  - saturation bound constants as functions of N;
  - bit-reverse function.
- Sub-module fft_bfly_r2: combinational butterfly with N, Q and SCALE parameters.
  - Inputs: A, B, W. Outputs: Y0, Y1 and a sat flag.
  - fft_r2_iter instantiates it once.

Test Plan:
- Bench ROM: tw_r=round(256·cos), tw_i=-round(256·sin); defaults N=16, Q=8, NPTS=16.
- Impulse, SCALE=0: x[0]=256, rest 0 → all 16 bins = 256+j0; ovf=0; first out_valid exactly 33 cycles after the last input is accepted.
- Impulse, SCALE=1: same stimulus → all bins = 16 (256/16); ovf=0.
- DC: all x=256+j0, SCALE=0 → X[0]=4096; other bins within ±2 LSB of 0.
- Nyquist: x[n]=(-1)^n·256 → X[8]=4096; other bins within ±2 LSB. Drive out_ready=0 for 3 cycles at bin 5 → out_r/out_i held stable; out_last only on bin 15.
- Overflow, SCALE=0: all x=32767 → X[0]=32767 (saturated); ovf=1 through UNLOAD. Next frame's first accepted sample clears ovf.
- Reset mid-COMPUTE at cycle 10: pulse rst_n low for 1 cycle → out_valid=0, in_ready=1. A following impulse frame yields the correct all-256 result.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the iterative radix-2 FFT engine.
// Holds the FSM state type, size helpers and saturation bounds.
package fft_pkg;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        UNLOAD
    } state_t;

    function automatic int log2n(input int npts);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < npts) r = i + 1;
        end
        return r;
    endfunction

    function automatic longint sat_hi(input int n);
        return (longint'(1) << (n - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int n);
        return -(longint'(1) << (n - 1));
    endfunction

    function automatic int unsigned bitrev(input int unsigned v,
                                           input int bits);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < bits) r[bits-1-i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_r2_iter_if.sv
// Sample-in / bin-out valid/ready streams of the FFT engine.
// master drives samples and takes bins; slave is the engine.
interface fft_r2_iter_if #(
    parameter int N = 16
) ();
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] in_r;
    logic signed [N-1:0] in_i;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] out_r;
    logic signed [N-1:0] out_i;
    logic                out_last;

    modport master (
        output in_valid, in_r, in_i, out_ready,
        input  in_ready, out_valid, out_r, out_i, out_last
    );

    modport slave (
        input  in_valid, in_r, in_i, out_ready,
        output in_ready, out_valid, out_r, out_i, out_last
    );
endinterface

// File: rtl/fft_bfly_r2.sv
// Combinational radix-2 DIT butterfly: Y0 = A + B*W, Y1 = A - B*W.
// Optional halving per stage, then saturation to N bits.
module fft_bfly_r2
    import fft_pkg::*;
#(
    parameter int N     = 16,
    parameter int Q     = 8,
    parameter int SCALE = 0
) (
    input  logic signed [N-1:0] a_r,
    input  logic signed [N-1:0] a_i,
    input  logic signed [N-1:0] b_r,
    input  logic signed [N-1:0] b_i,
    input  logic signed [N-1:0] w_r,
    input  logic signed [N-1:0] w_i,
    output logic signed [N-1:0] y0_r,
    output logic signed [N-1:0] y0_i,
    output logic signed [N-1:0] y1_r,
    output logic signed [N-1:0] y1_i,
    output logic                sat
);
    localparam int W = 2 * N + 1;
    localparam int S = N + 2;
    localparam logic signed [S-1:0] HI = S'(sat_hi(N));
    localparam logic signed [S-1:0] LO = S'(sat_lo(N));

    logic signed [W-1:0] pr_w;
    logic signed [W-1:0] pi_w;
    logic signed [N:0]   p_r;
    logic signed [N:0]   p_i;
    logic signed [S-1:0] s [4];
    logic signed [N-1:0] y [4];

    function automatic logic signed [S-1:0] post(
        input logic signed [S-1:0] v
    );
        return (SCALE != 0) ? (v >>> 1) : v;
    endfunction

    always_comb begin
        pr_w = W'(b_r) * W'(w_r) - W'(b_i) * W'(w_i);
        pi_w = W'(b_r) * W'(w_i) + W'(b_i) * W'(w_r);
        p_r  = (N+1)'(pr_w >>> Q);
        p_i  = (N+1)'(pi_w >>> Q);
        s[0] = post(S'(a_r) + S'(p_r));
        s[1] = post(S'(a_i) + S'(p_i));
        s[2] = post(S'(a_r) - S'(p_r));
        s[3] = post(S'(a_i) - S'(p_i));
        sat  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            y[i] = N'(s[i]);
            if (s[i] > HI) begin
                y[i] = N'(HI);
                sat  = 1'b1;
            end else if (s[i] < LO) begin
                y[i] = N'(LO);
                sat  = 1'b1;
            end
        end
    end

    assign y0_r = y[0];
    assign y0_i = y[1];
    assign y1_r = y[2];
    assign y1_i = y[3];

endmodule

// File: rtl/fft_r2_iter.sv
// Iterative in-place radix-2 DIT FFT: bit-reversed load, one
// butterfly per cycle over all stages, natural-order unload.
module fft_r2_iter
    import fft_pkg::*;
#(
    parameter int N     = 16,
    parameter int Q     = 8,
    parameter int NPTS  = 16,
    parameter int LOG2N = log2n(NPTS),
    parameter int SCALE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_r2_iter_if.slave         io,
    output logic [LOG2N-2:0]     tw_addr,
    input  logic signed [N-1:0]  tw_r,
    input  logic signed [N-1:0]  tw_i,
    output logic                 busy,
    output logic                 ovf
);
    localparam int SW = $clog2(LOG2N);
    localparam int JW = LOG2N - 1;

    state_t state, state_nx;

    logic [LOG2N-1:0] load_cnt;
    logic [LOG2N-1:0] unl_cnt;
    logic [SW-1:0]    stage;
    logic [JW-1:0]    bf;

    logic signed [N-1:0] mem_r [NPTS];
    logic signed [N-1:0] mem_i [NPTS];

    logic [LOG2N-1:0] jx, half, k, a, b;
    logic signed [N-1:0] y0_r, y0_i, y1_r, y1_i;
    logic sat, take, give, bf_wrap, last_bf;

    assign take    = (state == LOAD) && io.in_valid;
    assign give    = (state == UNLOAD) && io.out_ready;
    assign bf_wrap = &bf;
    assign last_bf = bf_wrap && (stage == SW'(LOG2N - 1));

    // Butterfly j of stage s pairs a and a+2^s inside blocks of 2^(s+1).
    always_comb begin
        jx      = {1'b0, bf};
        half    = LOG2N'(1) << stage;
        k       = jx & (half - 1'b1);
        a       = (((jx >> stage) << stage) << 1) | k;
        b       = a | half;
        tw_addr = '0;
        if (busy) tw_addr = JW'(k << (JW - int'(stage)));
    end

    always_comb begin
        state_nx     = state;
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        busy         = 1'b0;
        unique case (state)
            LOAD: begin
                io.in_ready = 1'b1;
                if (take && &load_cnt) state_nx = COMPUTE;
            end
            COMPUTE: begin
                busy = 1'b1;
                if (last_bf) state_nx = UNLOAD;
            end
            UNLOAD: begin
                io.out_valid = 1'b1;
                if (give && &unl_cnt) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    assign io.out_r    = (state == UNLOAD) ? mem_r[unl_cnt] : '0;
    assign io.out_i    = (state == UNLOAD) ? mem_i[unl_cnt] : '0;
    assign io.out_last = (state == UNLOAD) && (&unl_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            load_cnt <= '0;
            unl_cnt  <= '0;
            stage    <= '0;
            bf       <= '0;
            ovf      <= 1'b0;
        end else begin
            state <= state_nx;
            if (take) begin
                load_cnt <= load_cnt + 1'b1;
                if (load_cnt == '0) ovf <= 1'b0;
            end
            if (busy) begin
                bf <= bf + 1'b1;
                if (bf_wrap) stage <= last_bf ? '0 : stage + 1'b1;
                if (sat) ovf <= 1'b1;
            end
            if (give) unl_cnt <= unl_cnt + 1'b1;
        end
    end

    // Sample storage carries no reset; contents are rebuilt every frame.
    always_ff @(posedge clk) begin
        if (take) begin
            mem_r[LOG2N'(bitrev(32'(load_cnt), LOG2N))] <= io.in_r;
            mem_i[LOG2N'(bitrev(32'(load_cnt), LOG2N))] <= io.in_i;
        end else if (busy) begin
            mem_r[a] <= y0_r;
            mem_i[a] <= y0_i;
            mem_r[b] <= y1_r;
            mem_i[b] <= y1_i;
        end
    end

    fft_bfly_r2 #(
        .N     (N),
        .Q     (Q),
        .SCALE (SCALE)
    ) u_bfly (
        .a_r  (mem_r[a]),
        .a_i  (mem_i[a]),
        .b_r  (mem_r[b]),
        .b_i  (mem_i[b]),
        .w_r  (tw_r),
        .w_i  (tw_i),
        .y0_r (y0_r),
        .y0_i (y0_i),
        .y1_r (y1_r),
        .y1_i (y1_i),
        .sat  (sat)
    );

endmodule

// File: tb/tb_fft_r2_iter.sv
// Bench for fft_r2_iter: saturating and scaling instances run in
// lockstep and are checked against a floating-point DFT.
module tb_fft_r2_iter;
    localparam int NP = 16;
    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_r2_iter_if #(.N(16)) io0 ();
    fft_r2_iter_if #(.N(16)) io1 ();

    logic [2:0] ta0, ta1;
    logic signed [15:0] tr0, ti0, tr1, ti1;
    logic busy0, busy1, ovf0, ovf1;
    int twr_tab [8];
    int twi_tab [8];

    assign tr0 = 16'(twr_tab[ta0]);
    assign ti0 = 16'(twi_tab[ta0]);
    assign tr1 = 16'(twr_tab[ta1]);
    assign ti1 = 16'(twi_tab[ta1]);

    fft_r2_iter #(.N(16), .Q(8), .NPTS(NP), .SCALE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .io(io0), .tw_addr(ta0),
        .tw_r(tr0), .tw_i(ti0), .busy(busy0), .ovf(ovf0)
    );

    fft_r2_iter #(.N(16), .Q(8), .NPTS(NP), .SCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .io(io1), .tw_addr(ta1),
        .tw_r(tr1), .tw_i(ti1), .busy(busy1), .ovf(ovf1)
    );

    int  fr_r [NP];
    int  fr_i [NP];
    real xr [NP];
    real xi [NP];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  tol0, tol1, stall_bin;
    bit  chk_all, ovf_exp;

    function automatic int rnd(input real v);
        return $rtoi(v + ((v >= 0.0) ? 0.5 : -0.5));
    endfunction

    function automatic int clip(input real v);
        int t;
        t = rnd(v);
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        return t;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag,
                           input logic signed [31:0] obs,
                           input int exp, input int tol);
        logic ok;
        ok = (obs - exp <= tol) && (exp - obs <= tol);
        n_cmp++;
        assert (ok === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d +/-%0d", tag, obs, exp, tol);
        end
    endtask

    // Direct DFT of the frame in floating point.
    task automatic model();
        real sr, si, c, s;
        for (int k = 0; k < NP; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < NP; n++) begin
                c  = $cos(2.0 * PI * n * k / NP);
                s  = $sin(2.0 * PI * n * k / NP);
                sr = sr + fr_r[n] * c + fr_i[n] * s;
                si = si + fr_i[n] * c - fr_r[n] * s;
            end
            xr[k] = sr;
            xi[k] = si;
        end
    endtask

    task automatic drive_in(input bit v, input int r, input int i);
        io0.in_valid = v;
        io1.in_valid = v;
        io0.in_r = 16'(r);
        io1.in_r = 16'(r);
        io0.in_i = 16'(i);
        io1.in_i = 16'(i);
    endtask

    task automatic set_ready(input bit v);
        io0.out_ready = v;
        io1.out_ready = v;
    endtask

    task automatic load_frame(input string name);
        for (int n = 0; n < NP; n++) begin
            drive_in(1'b1, fr_r[n], fr_i[n]);
            @(posedge clk);
            #1;
            if (n == 0) chk({name, ".ovf_clr"}, ovf0, 0);
        end
        drive_in(1'b0, 0, 0);
    endtask

    task automatic run_frame(input string name);
        int edges;
        int e0r, e0i, e1r, e1i;
        model();
        load_frame(name);
        chk({name, ".busy"}, busy0, 1);
        chk({name, ".rdy_cmp"}, io0.in_ready, 0);
        drive_in(1'b1, 12345, -4321);
        edges = 1;
        while (io0.out_valid !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        drive_in(1'b0, 0, 0);
        chk({name, ".latency"}, edges, 33);
        chk({name, ".busy_unl"}, busy0, 0);
        for (int b = 0; b < NP; b++) begin
            e0r = clip(xr[b]);
            e0i = clip(xi[b]);
            e1r = clip(xr[b] / NP);
            e1i = clip(xi[b] / NP);
            if (b == stall_bin) begin
                set_ready(1'b0);
                for (int h = 0; h < 3; h++) begin
                    @(posedge clk);
                    #1;
                    chk_tol($sformatf("%s.hold_r[%0d]", name, h),
                            io0.out_r, e0r, tol0);
                    chk_tol($sformatf("%s.hold_i[%0d]", name, h),
                            io0.out_i, e0i, tol0);
                    chk({name, ".hold_v"}, io0.out_valid, 1);
                end
                set_ready(1'b1);
            end
            if (chk_all || b == 0) begin
                chk_tol($sformatf("%s.r0[%0d]", name, b),
                        io0.out_r, e0r, tol0);
                chk_tol($sformatf("%s.i0[%0d]", name, b),
                        io0.out_i, e0i, tol0);
            end
            chk_tol($sformatf("%s.r1[%0d]", name, b),
                    io1.out_r, e1r, tol1);
            chk_tol($sformatf("%s.i1[%0d]", name, b),
                    io1.out_i, e1i, tol1);
            chk($sformatf("%s.valid[%0d]", name, b), io0.out_valid, 1);
            chk($sformatf("%s.last[%0d]", name, b),
                io0.out_last, 32'(b == NP - 1));
            if (b == 0 || b == NP - 1)
                chk($sformatf("%s.ovf[%0d]", name, b), ovf0, 32'(ovf_exp));
            @(posedge clk);
            #1;
        end
        chk({name, ".done_v"}, io0.out_valid, 0);
        chk({name, ".done_rdy"}, io0.in_ready, 1);
    endtask

    task automatic set_frame(input int kind);
        int sum;
        sum = 0;
        for (int n = 0; n < NP; n++) begin
            fr_i[n] = 0;
            unique case (kind)
                0: fr_r[n] = (n == 0) ? 256 : 0;
                1: fr_r[n] = 256;
                2: fr_r[n] = (n % 2 == 1) ? -256 : 256;
                3: fr_r[n] = 32767;
                default: begin
                    fr_r[n] = int'($urandom_range(510)) - 255;
                    fr_i[n] = int'($urandom_range(510)) - 255;
                end
            endcase
            sum += (fr_r[n] < 0 ? -fr_r[n] : fr_r[n]);
            sum += (fr_i[n] < 0 ? -fr_i[n] : fr_i[n]);
        end
        chk_all   = (kind != 3);
        ovf_exp   = (kind == 3);
        stall_bin = (kind == 2) ? 5 : -1;
        tol0      = (kind == 0 || kind == 3) ? 0 : 2;
        tol1      = (kind == 0) ? 0 : 2;
        if (kind > 3) begin
            tol0 = 4 + sum / 64;
            tol1 = 6 + sum / 512;
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            twr_tab[k] = rnd(256.0 * $cos(2.0 * PI * k / NP));
            twi_tab[k] = -rnd(256.0 * $sin(2.0 * PI * k / NP));
        end
        drive_in(1'b0, 0, 0);
        set_ready(1'b1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", io0.out_valid, 0);
        chk("rst.out_last", io0.out_last, 0);
        chk("rst.out_r", io0.out_r, 0);
        chk("rst.busy", busy0, 0);
        chk("rst.ovf", ovf0, 0);
        chk("rst.tw_addr", ta0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.in_ready", io0.in_ready, 1);

        set_frame(0);
        run_frame("impulse");
        set_frame(1);
        run_frame("dc");
        set_frame(2);
        run_frame("nyquist");
        set_frame(3);
        run_frame("ovf");
        for (int f = 0; f < 3; f++) begin
            set_frame(4 + f);
            run_frame($sformatf("rand%0d", f));
        end

        set_frame(0);
        load_frame("abort");
        repeat (10) @(posedge clk);
        #1;
        chk("abort.busy", busy0, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("abort.out_valid", io0.out_valid, 0);
        chk("abort.in_ready", io0.in_ready, 1);
        chk("abort.busy", busy0, 0);
        chk("abort.in_ready1", io1.in_ready, 1);
        @(posedge clk);
        #1;
        run_frame("post_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
